// File: rtl/cp0_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : cp0_ctrl_param
// Description : Coprocessor-0 control block for the multi-cycle MIPS core.
//               Holds Count, Compare, Status, Cause, EPC, BadVAddr, PRId and
//               Config, runs the Count/Compare timer, resolves masked
//               interrupts into a single request and records exception/ERET
//               state. Interrupt line count, timer routing and ID constants
//               are parameters so one block serves every core variant.
// Options     : CP0_COUNT_DIV2_EN - when defined, Count advances every second
//               cycle (internal phase toggle, cleared by a Count write).
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_ctrl_param #(
  parameter int          NUM_HW_INT     = 6,
  parameter int          TIMER_IRQ_LINE = 5,
  parameter logic [31:0] PRID_VAL       = 32'h004C0102,
  parameter logic [31:0] CONFIG_VAL     = 32'h00008000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [4:0]            raddr_i,
  output logic [31:0]           rdata_o,
  input  logic [NUM_HW_INT-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_in_ds_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  int_req_o,
  output logic                  timer_int_o
);

  // CP0 register numbers
  localparam logic [4:0] C_REG_BADVADDR = 5'd8;
  localparam logic [4:0] C_REG_COUNT    = 5'd9;
  localparam logic [4:0] C_REG_COMPARE  = 5'd11;
  localparam logic [4:0] C_REG_STATUS   = 5'd12;
  localparam logic [4:0] C_REG_CAUSE    = 5'd13;
  localparam logic [4:0] C_REG_EPC      = 5'd14;
  localparam logic [4:0] C_REG_PRID     = 5'd15;
  localparam logic [4:0] C_REG_CONFIG   = 5'd16;

  // ExcCodes that carry a faulting address (AdEL / AdES)
  localparam logic [4:0] C_EXC_ADEL = 5'd4;
  localparam logic [4:0] C_EXC_ADES = 5'd5;

  // Cause.IP has six hardware slots regardless of how many lines are wired
  localparam int C_IP_HW_SLOTS = 6;

  // --------------------------------------------------------------------------
  // Architectural state
  // --------------------------------------------------------------------------
  logic [31:0]           r_count;
  logic [31:0]           r_compare;
  logic                  r_timer_int;
  logic [7:0]            r_status_im;
  logic                  r_status_exl;
  logic                  r_status_ie;
  logic                  r_cause_bd;
  logic [1:0]            r_cause_ip_sw;
  logic [4:0]            r_cause_exc;
  logic [NUM_HW_INT-1:0] r_int_q;
  logic [31:0]           r_epc;
  logic [31:0]           r_badvaddr;

  // --------------------------------------------------------------------------
  // MTC0 write decode
  // --------------------------------------------------------------------------
  logic w_wr_count;
  logic w_wr_compare;
  logic w_wr_status;
  logic w_wr_cause;
  logic w_wr_epc;

  assign w_wr_count   = we_i && (waddr_i == C_REG_COUNT);
  assign w_wr_compare = we_i && (waddr_i == C_REG_COMPARE);
  assign w_wr_status  = we_i && (waddr_i == C_REG_STATUS);
  assign w_wr_cause   = we_i && (waddr_i == C_REG_CAUSE);
  assign w_wr_epc     = we_i && (waddr_i == C_REG_EPC);

  // Address-type exceptions also latch the faulting virtual address
  logic w_exc_has_addr;
  assign w_exc_has_addr = (exc_code_i == C_EXC_ADEL) || (exc_code_i == C_EXC_ADES);

  // A Compare of zero disarms the timer, so only a non-zero match counts
  logic w_timer_match;
  assign w_timer_match = (r_count == r_compare) && (r_compare != 32'd0);

  // --------------------------------------------------------------------------
  // Count
  // --------------------------------------------------------------------------
`ifdef CP0_COUNT_DIV2_EN
  logic r_count_phase;

  // Count advances only when the phase bit is set; a write restarts the phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count       <= 32'd0;
      r_count_phase <= 1'b0;
    end else if (w_wr_count) begin
      r_count       <= wdata_i;
      r_count_phase <= 1'b0;
    end else begin
      r_count_phase <= ~r_count_phase;
      if (r_count_phase) begin
        r_count <= r_count + 32'd1;
      end
    end
  end
`else
  // Count advances every cycle and wraps naturally; a write overrides it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 32'd0;
    end else if (w_wr_count) begin
      r_count <= wdata_i;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Compare and timer interrupt
  // --------------------------------------------------------------------------

  // Compare only changes through MTC0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_compare <= 32'd0;
    end else if (w_wr_compare) begin
      r_compare <= wdata_i;
    end
  end

  // Timer is sticky after a match; writing Compare acknowledges it and beats
  // a match in the same cycle so software never sees a stale re-assertion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer_int <= 1'b0;
    end else if (w_wr_compare) begin
      r_timer_int <= 1'b0;
    end else if (w_timer_match) begin
      r_timer_int <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Hardware interrupt sampling and Cause.IP assembly
  // --------------------------------------------------------------------------

  // Interrupt levels are sampled once per cycle into Cause.IP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_q <= '0;
    end else begin
      r_int_q <= int_i;
    end
  end

  logic [C_IP_HW_SLOTS-1:0] w_ip_hw;

  // Unwired slots read zero; the timer is merged onto its configured line
  for (genvar k = 0; k < C_IP_HW_SLOTS; k++) begin : g_ip_hw
    if (k < NUM_HW_INT) begin : g_live
      if (k == TIMER_IRQ_LINE) begin : g_timer
        assign w_ip_hw[k] = r_int_q[k] | r_timer_int;
      end else begin : g_plain
        assign w_ip_hw[k] = r_int_q[k];
      end
    end else begin : g_tied
      assign w_ip_hw[k] = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Status
  // --------------------------------------------------------------------------

  // IM/IE belong to MTC0 alone; EXL is arbitrated exception > ERET > MTC0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status_im  <= 8'h00;
      r_status_exl <= 1'b0;
      r_status_ie  <= 1'b0;
    end else begin
      if (w_wr_status) begin
        r_status_im <= wdata_i[15:8];
        r_status_ie <= wdata_i[0];
      end
      if (exc_valid_i) begin
        r_status_exl <= 1'b1;
      end else if (eret_i) begin
        r_status_exl <= 1'b0;
      end else if (w_wr_status) begin
        r_status_exl <= wdata_i[1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Cause
  // --------------------------------------------------------------------------

  // Software IP bits come only from MTC0; BD/ExcCode come only from exceptions.
  // BD is frozen while EXL is set so a nested exception keeps the first one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cause_bd    <= 1'b0;
      r_cause_ip_sw <= 2'b00;
      r_cause_exc   <= 5'd0;
    end else begin
      if (w_wr_cause) begin
        r_cause_ip_sw <= wdata_i[9:8];
      end
      if (exc_valid_i) begin
        r_cause_exc <= exc_code_i;
        if (!r_status_exl) begin
          r_cause_bd <= exc_in_ds_i;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // EPC and BadVAddr
  // --------------------------------------------------------------------------

  // An exception owns EPC for its cycle even when EXL leaves it unchanged,
  // so a coincident MTC0 to EPC is dropped. Delay-slot faults restart at the
  // branch, one word earlier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_epc <= 32'd0;
    end else if (exc_valid_i) begin
      if (!r_status_exl) begin
        r_epc <= exc_in_ds_i ? (exc_pc_i - 32'd4) : exc_pc_i;
      end
    end else if (w_wr_epc) begin
      r_epc <= wdata_i;
    end
  end

  // BadVAddr is read-only to software and only captures address errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_badvaddr <= 32'd0;
    end else if (exc_valid_i && w_exc_has_addr) begin
      r_badvaddr <= exc_badvaddr_i;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------

  // Status: CU0-style bit 28 hard-wired to 1, unimplemented bits read 0
  assign status_o = {3'b000, 1'b1, 12'h000, r_status_im, 6'b000000,
                     r_status_exl, r_status_ie};

  // Cause: BD, TI, IP[7:2] hardware, IP[1:0] software, ExcCode
  assign cause_o = {r_cause_bd, r_timer_int, 14'h0000, w_ip_hw, r_cause_ip_sw,
                    1'b0, r_cause_exc, 2'b00};

  assign epc_o       = r_epc;
  assign timer_int_o = r_timer_int;

  // Interrupts are taken only with IE set and outside exception level
  assign int_req_o = r_status_ie & ~r_status_exl & (|(cause_o[15:8] & r_status_im));

  // MFC0 read mux over registered state; a same-cycle MTC0 is not visible
  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      C_REG_BADVADDR: rdata_o = r_badvaddr;
      C_REG_COUNT:    rdata_o = r_count;
      C_REG_COMPARE:  rdata_o = r_compare;
      C_REG_STATUS:   rdata_o = status_o;
      C_REG_CAUSE:    rdata_o = cause_o;
      C_REG_EPC:      rdata_o = r_epc;
      C_REG_PRID:     rdata_o = PRID_VAL;
      C_REG_CONFIG:   rdata_o = CONFIG_VAL;
      default:        rdata_o = 32'd0;
    endcase
  end

endmodule
`default_nettype wire
